led_ram_arbiter: RTL and testbench

- Arbitrates the single access port of the 8x8 LED display RAM (4-bit cells: bit3 valid/bright, bits2:1 colour, bit0 reserved) among three requesters: the scan reader, light-pen writes, and a built-in bulk clear/fill engine.
- Sits between scan_driver / light-pen logic / main state machine and led_ram.
- Drives registered one-hot row/col addresses, write enable and write data.
- Guarantees bounded wait for pen and clear traffic under continuous scan load.

---
 rtl/led_ram_arbiter.sv | 208 ++++++++++++++++++++
 tb/tb_led_ram_arbiter.sv | 473 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_ram_arbiter.sv
// LED display RAM port arbiter: scan reads, light-pen writes, bulk clear/fill.
// Scan wins by default; a pending writer gets a slot within SCAN_BURST+1.
module led_ram_arbiter #(
    parameter int unsigned SCAN_BURST = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scan_req,
    input  logic [7:0] scan_row,
    input  logic [7:0] scan_col,
    output logic       scan_gnt,
    input  logic       pen_req,
    input  logic [7:0] pen_row,
    input  logic [7:0] pen_col,
    input  logic [3:0] pen_data,
    output logic       pen_ack,
    output logic       pen_err,
    input  logic       clr_start,
    input  logic [3:0] clr_data,
    output logic       clr_busy,
    output logic       clr_done,
    output logic       ram_we,
    output logic [7:0] ram_row,
    output logic [7:0] ram_col,
    output logic [3:0] ram_wdata
);

    typedef enum logic [1:0] {
        CLR_IDLE = 2'd0,
        CLR_RUN  = 2'd1,
        CLR_DONE = 2'd2
    } clr_state_t;

    localparam logic [3:0] BURST = 4'(SCAN_BURST);

    clr_state_t r_clr_state;
    clr_state_t w_clr_state_nxt;

    logic [5:0] r_idx;
    logic [5:0] w_idx_nxt;
    logic [3:0] r_clr_data;
    logic [3:0] w_clr_data_nxt;
    logic [3:0] r_fair_cnt;
    logic [3:0] w_fair_cnt_nxt;

    logic       r_scan_gnt;
    logic       r_pen_ack;
    logic       r_pen_err;
    logic       r_clr_busy;
    logic       r_clr_done;
    logic       r_ram_we;
    logic [7:0] r_ram_row;
    logic [7:0] r_ram_col;
    logic [3:0] r_ram_wdata;

    logic       w_clr_w;
    logic       w_pen_w;
    logic       w_any_w;
    logic       w_w_win;
    logic       w_scan_win;
    logic       w_pen_ok;
    logic [7:0] w_clr_row;
    logic [7:0] w_clr_col;

    logic       w_scan_gnt;
    logic       w_pen_ack;
    logic       w_pen_err;
    logic       w_ram_we;
    logic [7:0] w_ram_row;
    logic [7:0] w_ram_col;
    logic [3:0] w_ram_wdata;

    function automatic logic is_onehot(input logic [7:0] v);
        return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
    endfunction

    // The pen is ineligible while its ack is out, so a held req is not reused.
    always_comb begin
        w_clr_w    = (r_clr_state == CLR_RUN);
        w_pen_w    = !w_clr_w && pen_req && !r_pen_ack;
        w_any_w    = w_clr_w || w_pen_w;
        w_w_win    = w_any_w && (!scan_req || (r_fair_cnt == BURST));
        w_scan_win = scan_req && !w_w_win;
        w_pen_ok   = is_onehot(pen_row) && is_onehot(pen_col);
        w_clr_row  = 8'd1 << r_idx[5:3];
        w_clr_col  = 8'd1 << r_idx[2:0];
    end

    always_comb begin
        w_fair_cnt_nxt = 4'd0;
        if (w_any_w && w_scan_win) begin
            if (r_fair_cnt != BURST) begin
                w_fair_cnt_nxt = r_fair_cnt + 4'd1;
            end else begin
                w_fair_cnt_nxt = r_fair_cnt;
            end
        end
    end

    always_comb begin
        w_scan_gnt  = 1'b0;
        w_pen_ack   = 1'b0;
        w_pen_err   = 1'b0;
        w_ram_we    = 1'b0;
        w_ram_row   = 8'd0;
        w_ram_col   = 8'd0;
        w_ram_wdata = 4'd0;
        unique case (1'b1)
            w_scan_win: begin
                w_scan_gnt = 1'b1;
                w_ram_row  = scan_row;
                w_ram_col  = scan_col;
            end
            (w_w_win && w_clr_w): begin
                w_ram_we    = 1'b1;
                w_ram_row   = w_clr_row;
                w_ram_col   = w_clr_col;
                w_ram_wdata = r_clr_data;
            end
            (w_w_win && w_pen_w): begin
                w_pen_ack = 1'b1;
                w_pen_err = !w_pen_ok;
                if (w_pen_ok) begin
                    w_ram_we    = 1'b1;
                    w_ram_row   = pen_row;
                    w_ram_col   = pen_col;
                    w_ram_wdata = pen_data;
                end
            end
            default: begin
                w_scan_gnt = 1'b0;
            end
        endcase
    end

    always_comb begin
        w_clr_state_nxt = r_clr_state;
        w_idx_nxt       = r_idx;
        w_clr_data_nxt  = r_clr_data;
        unique case (r_clr_state)
            CLR_IDLE: begin
                if (clr_start) begin
                    w_clr_state_nxt = CLR_RUN;
                    w_idx_nxt       = 6'd0;
                    w_clr_data_nxt  = clr_data;
                end
            end
            CLR_RUN: begin
                if (w_w_win) begin
                    if (r_idx == 6'd63) begin
                        w_clr_state_nxt = CLR_DONE;
                    end else begin
                        w_idx_nxt = r_idx + 6'd1;
                    end
                end
            end
            CLR_DONE: begin
                w_clr_state_nxt = CLR_IDLE;
            end
            default: begin
                w_clr_state_nxt = CLR_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_clr_state <= CLR_IDLE;
            r_idx       <= 6'd0;
            r_clr_data  <= 4'd0;
            r_fair_cnt  <= 4'd0;
            r_scan_gnt  <= 1'b0;
            r_pen_ack   <= 1'b0;
            r_pen_err   <= 1'b0;
            r_clr_busy  <= 1'b0;
            r_clr_done  <= 1'b0;
            r_ram_we    <= 1'b0;
            r_ram_row   <= 8'd0;
            r_ram_col   <= 8'd0;
            r_ram_wdata <= 4'd0;
        end else begin
            r_clr_state <= w_clr_state_nxt;
            r_idx       <= w_idx_nxt;
            r_clr_data  <= w_clr_data_nxt;
            r_fair_cnt  <= w_fair_cnt_nxt;
            r_scan_gnt  <= w_scan_gnt;
            r_pen_ack   <= w_pen_ack;
            r_pen_err   <= w_pen_err;
            r_clr_busy  <= (w_clr_state_nxt == CLR_RUN);
            r_clr_done  <= (w_clr_state_nxt == CLR_DONE);
            r_ram_we    <= w_ram_we;
            r_ram_row   <= w_ram_row;
            r_ram_col   <= w_ram_col;
            r_ram_wdata <= w_ram_wdata;
        end
    end

    assign scan_gnt  = r_scan_gnt;
    assign pen_ack   = r_pen_ack;
    assign pen_err   = r_pen_err;
    assign clr_busy  = r_clr_busy;
    assign clr_done  = r_clr_done;
    assign ram_we    = r_ram_we;
    assign ram_row   = r_ram_row;
    assign ram_col   = r_ram_col;
    assign ram_wdata = r_ram_wdata;

endmodule

// File: tb/tb_led_ram_arbiter.sv
// Bench for led_ram_arbiter: directed scenarios plus a randomized run
// against a slot-level model of the scan/pen fairness rules.
module tb_led_ram_arbiter;

    localparam int SB = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scan_req = 1'b0;
    logic [7:0] scan_row = 8'd0;
    logic [7:0] scan_col = 8'd0;
    logic       scan_gnt;
    logic       pen_req = 1'b0;
    logic [7:0] pen_row = 8'd0;
    logic [7:0] pen_col = 8'd0;
    logic [3:0] pen_data = 4'd0;
    logic       pen_ack;
    logic       pen_err;
    logic       clr_start = 1'b0;
    logic [3:0] clr_data = 4'd0;
    logic       clr_busy;
    logic       clr_done;
    logic       ram_we;
    logic [7:0] ram_row;
    logic [7:0] ram_col;
    logic [3:0] ram_wdata;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    led_ram_arbiter #(.SCAN_BURST(SB)) dut (
        .clk(clk), .rst_n(rst_n),
        .scan_req(scan_req), .scan_row(scan_row), .scan_col(scan_col),
        .scan_gnt(scan_gnt),
        .pen_req(pen_req), .pen_row(pen_row), .pen_col(pen_col),
        .pen_data(pen_data), .pen_ack(pen_ack), .pen_err(pen_err),
        .clr_start(clr_start), .clr_data(clr_data),
        .clr_busy(clr_busy), .clr_done(clr_done),
        .ram_we(ram_we), .ram_row(ram_row), .ram_col(ram_col),
        .ram_wdata(ram_wdata)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        scan_req  = 1'b0;
        scan_row  = 8'd0;
        scan_col  = 8'd0;
        pen_req   = 1'b0;
        pen_row   = 8'd0;
        pen_col   = 8'd0;
        pen_data  = 4'd0;
        clr_start = 1'b0;
        clr_data  = 4'd0;
    endtask

    function automatic logic [7:0] rand_onehot();
        logic [7:0] v;
        v = 8'd1;
        return v << $urandom_range(7, 0);
    endfunction

    function automatic logic [7:0] rand_bad();
        logic [7:0] v;
        v = 8'd3;
        if ($urandom_range(2, 0) == 0) return 8'd0;
        return v << $urandom_range(6, 0);
    endfunction

    function automatic logic [23:0] outs();
        return {scan_gnt, pen_ack, pen_err, ram_we,
                ram_row, ram_col, ram_wdata};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        tick();
        tick();
        n_tests++;
        if ({scan_gnt, pen_ack, pen_err, ram_we, clr_busy, clr_done} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_flags got %b want 000000",
                     {scan_gnt, pen_ack, pen_err, ram_we, clr_busy, clr_done});
        end
        n_tests++;
        if ({ram_row, ram_col, ram_wdata} !== 20'd0) begin
            n_fail++;
            $display("FAIL reset_bus got %h want 00000",
                     {ram_row, ram_col, ram_wdata});
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_pen_only();
        logic [23:0] exp;
        idle_inputs();
        pen_req  = 1'b1;
        pen_row  = 8'h04;
        pen_col  = 8'h10;
        pen_data = 4'b1010;
        tick();
        exp = {1'b0, 1'b1, 1'b0, 1'b1, 8'h04, 8'h10, 4'b1010};
        n_tests++;
        if (outs() !== exp) begin
            n_fail++;
            $display("FAIL pen_write got %h want %h", outs(), exp);
        end
        tick();
        n_tests++;
        if ({pen_ack, ram_we} !== 2'b00) begin
            n_fail++;
            $display("FAIL pen_gap got ack/we %b want 00", {pen_ack, ram_we});
        end
        pen_req = 1'b0;
        tick();
        for (int i = 0; i < 8; i++) begin
            pen_req  = 1'b1;
            pen_row  = rand_onehot();
            pen_col  = rand_onehot();
            pen_data = 4'($urandom);
            tick();
            exp = {1'b0, 1'b1, 1'b0, 1'b1, pen_row, pen_col, pen_data};
            n_tests++;
            if (outs() !== exp) begin
                n_fail++;
                $display("FAIL pen_rand%0d got %h want %h", i, outs(), exp);
            end
            pen_req = 1'b0;
            tick();
        end
    endtask

    task automatic test_bad_addr();
        idle_inputs();
        pen_req  = 1'b1;
        pen_row  = 8'h03;
        pen_col  = 8'h01;
        pen_data = 4'hF;
        tick();
        n_tests++;
        if ({pen_ack, pen_err, ram_we} !== 3'b110) begin
            n_fail++;
            $display("FAIL bad_addr got ack/err/we %b want 110",
                     {pen_ack, pen_err, ram_we});
        end
        pen_req = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            pen_req = 1'b1;
            if (i[0]) begin
                pen_row = rand_onehot();
                pen_col = rand_bad();
            end else begin
                pen_row = rand_bad();
                pen_col = rand_onehot();
            end
            tick();
            n_tests++;
            if ({pen_ack, pen_err, ram_we} !== 3'b110) begin
                n_fail++;
                $display("FAIL bad_rand%0d got ack/err/we %b want 110",
                         i, {pen_ack, pen_err, ram_we});
            end
            pen_req = 1'b0;
            tick();
        end
    endtask

    task automatic test_fairness();
        int   scans;
        bit   acked;
        logic [7:0] sr;
        logic [7:0] sc;
        idle_inputs();
        tick();
        scans    = 0;
        acked    = 1'b0;
        scan_req = 1'b1;
        pen_req  = 1'b1;
        pen_row  = 8'h80;
        pen_col  = 8'h02;
        pen_data = 4'h6;
        for (int i = 0; i < 12 && !acked; i++) begin
            sr = 8'($urandom);
            sc = 8'($urandom);
            scan_row = sr;
            scan_col = sc;
            tick();
            if (pen_ack) begin
                acked = 1'b1;
                n_tests++;
                if ({ram_we, ram_row, ram_col, ram_wdata} !== {1'b1, 8'h80, 8'h02, 4'h6}) begin
                    n_fail++;
                    $display("FAIL fair_pen_slot got %h want 18002 6",
                             {ram_we, ram_row, ram_col, ram_wdata});
                end
            end else if (scan_gnt && !ram_we && ram_row == sr && ram_col == sc) begin
                scans++;
            end
        end
        n_tests++;
        if (!acked || scans != SB) begin
            n_fail++;
            $display("FAIL fair_count got acked=%0d scans=%0d want 1/%0d",
                     acked, scans, SB);
        end
        pen_req  = 1'b0;
        sr       = 8'($urandom);
        scan_row = sr;
        tick();
        n_tests++;
        if (scan_gnt !== 1'b1 || ram_row !== sr) begin
            n_fail++;
            $display("FAIL fair_resume got gnt=%b row=%h want 1/%h",
                     scan_gnt, ram_row, sr);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_clear();
        logic [3:0] d;
        int writes, dones, gap, max_gap, order_err, busy_err;
        int pen_early;
        bit pen_acked;
        idle_inputs();
        tick();
        d = 4'($urandom);
        writes = 0; dones = 0; gap = 0; max_gap = 0;
        order_err = 0; busy_err = 0; pen_early = 0; pen_acked = 1'b0;
        scan_req  = 1'b1;
        clr_data  = d;
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        clr_data  = ~d;
        for (int i = 0; i < 800 && !(pen_acked && dones > 0); i++) begin
            scan_row = 8'($urandom);
            scan_col = 8'($urandom);
            if (writes == 10 && !pen_req && dones == 0) begin
                pen_req  = 1'b1;
                pen_row  = 8'h08;
                pen_col  = 8'h08;
                pen_data = 4'h9;
            end
            tick();
            if (pen_ack) begin
                if (dones == 0) pen_early++;
                else pen_acked = 1'b1;
                pen_req = 1'b0;
            end else if (ram_we) begin
                if (ram_row !== (8'd1 << (writes / 8)) ||
                    ram_col !== (8'd1 << (writes % 8)) || ram_wdata !== d)
                    order_err++;
                if (!clr_busy && !clr_done) busy_err++;
                if (gap > max_gap) max_gap = gap;
                gap = 0;
                writes++;
            end else if (scan_gnt) begin
                gap++;
            end
            if (clr_done) dones++;
        end
        n_tests++;
        if (writes != 64 || dones != 1) begin
            n_fail++;
            $display("FAIL clr_count got writes=%0d dones=%0d want 64/1",
                     writes, dones);
        end
        n_tests++;
        if (order_err != 0 || busy_err != 0) begin
            n_fail++;
            $display("FAIL clr_order got order_err=%0d busy_err=%0d want 0/0",
                     order_err, busy_err);
        end
        n_tests++;
        if (max_gap > SB) begin
            n_fail++;
            $display("FAIL clr_gap got %0d want <=%0d", max_gap, SB);
        end
        n_tests++;
        if (pen_early != 0 || !pen_acked) begin
            n_fail++;
            $display("FAIL clr_pen got early=%0d acked=%0d want 0/1",
                     pen_early, pen_acked);
        end
        idle_inputs();
        tick();
        n_tests++;
        if (clr_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_idle_busy got %b want 0", clr_busy);
        end
    endtask

    task automatic test_clear_restart();
        logic [3:0] d1;
        int writes, dones, data_err, tail;
        idle_inputs();
        tick();
        d1 = 4'($urandom);
        writes = 0; dones = 0; data_err = 0; tail = 0;
        clr_data  = d1;
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        for (int i = 0; i < 800 && tail < 10; i++) begin
            scan_req = 1'($urandom);
            scan_row = 8'($urandom);
            scan_col = 8'($urandom);
            if (writes == 10 && dones == 0) begin
                clr_start = 1'b1;
                clr_data  = d1 ^ 4'h5;
            end else begin
                clr_start = 1'b0;
            end
            tick();
            if (ram_we) begin
                if (ram_wdata !== d1) data_err++;
                writes++;
            end
            if (clr_done) dones++;
            if (dones > 0) tail++;
        end
        n_tests++;
        if (writes != 64 || dones != 1 || data_err != 0) begin
            n_fail++;
            $display("FAIL clr_restart got writes=%0d dones=%0d data_err=%0d want 64/1/0",
                     writes, dones, data_err);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_reset_mid_clear();
        int writes, err;
        bit found;
        idle_inputs();
        tick();
        writes = 0; err = 0; found = 1'b0;
        clr_data  = 4'hE;
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        for (int i = 0; i < 100 && writes < 20; i++) begin
            tick();
            if (ram_we) writes++;
        end
        rst_n = 1'b0;
        tick();
        n_tests++;
        if ({ram_we, clr_busy, clr_done, ram_row, ram_col, ram_wdata} !== 23'd0) begin
            n_fail++;
            $display("FAIL rst_mid got %h want 0",
                     {ram_we, clr_busy, clr_done, ram_row, ram_col, ram_wdata});
        end
        rst_n = 1'b1;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (ram_we || clr_busy || clr_done) err++;
        end
        n_tests++;
        if (err != 0) begin
            n_fail++;
            $display("FAIL rst_abort got %0d active cycles want 0", err);
        end
        clr_data  = 4'h3;
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        for (int i = 0; i < 5 && !found; i++) begin
            tick();
            if (ram_we) begin
                found = 1'b1;
                n_tests++;
                if ({ram_row, ram_col, ram_wdata} !== {8'h01, 8'h01, 4'h3}) begin
                    n_fail++;
                    $display("FAIL rst_restart got %h want 01013",
                             {ram_row, ram_col, ram_wdata});
                end
            end
        end
        n_tests++;
        if (!found) begin
            n_fail++;
            $display("FAIL rst_restart_timeout got no write want one");
        end
        for (int i = 0; i < 80 && !clr_done; i++) tick();
        idle_inputs();
        tick();
        tick();
    endtask

    task automatic test_random();
        int streak, waited;
        bit last_ack, w, pen_win, scan_win, ok;
        logic [23:0] exp;
        int bad_cycles, bound_err;
        idle_inputs();
        tick();
        tick();
        streak = 0; waited = 0; last_ack = 1'b0;
        bad_cycles = 0; bound_err = 0;
        for (int i = 0; i < 400; i++) begin
            if (!pen_req || last_ack) begin
                pen_req  = ($urandom_range(2, 0) == 0);
                pen_row  = ($urandom_range(4, 0) == 0) ? rand_bad() : rand_onehot();
                pen_col  = rand_onehot();
                pen_data = 4'($urandom);
            end
            scan_req = ($urandom_range(3, 0) != 0);
            scan_row = 8'($urandom);
            scan_col = 8'($urandom);
            w        = pen_req && !last_ack;
            pen_win  = w && (!scan_req || streak == SB);
            scan_win = scan_req && !pen_win;
            ok       = ($countones(pen_row) == 1) && ($countones(pen_col) == 1);
            if (scan_win)
                exp = {4'b1000, scan_row, scan_col, 4'd0};
            else if (pen_win && ok)
                exp = {4'b0101, pen_row, pen_col, pen_data};
            else if (pen_win)
                exp = {4'b0110, 20'd0};
            else
                exp = 24'd0;
            tick();
            n_tests++;
            if (outs() !== exp) begin
                n_fail++;
                bad_cycles++;
                if (bad_cycles <= 5)
                    $display("FAIL rand_cycle%0d got %h want %h", i, outs(), exp);
            end
            if (pen_win) begin
                n_tests++;
                if (waited > SB) begin
                    n_fail++;
                    bound_err++;
                    $display("FAIL rand_wait got %0d lost slots want <=%0d", waited, SB);
                end
                waited = 0;
            end else if (w) begin
                waited++;
            end
            if (!w || pen_win) streak = 0;
            else streak++;
            last_ack = pen_win;
        end
        idle_inputs();
        tick();
    endtask

    initial begin
        test_reset();
        test_pen_only();
        test_bad_addr();
        test_fairness();
        test_clear();
        test_clear_restart();
        test_reset_mid_clear();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
